// File: rtl/riscv_pkg.sv
// Shared RISC-V datapath encodings for the load/store and write-back stage.
// Contents: write-back source select, memory-op codes, funct3 access sizes,
// LSU FSM state type, and store lane helpers (byte enables, lane replication).
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  // Write-back source select (value 3 is reserved and behaves as ALU)
  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  // Memory operation (value 3 is unused and behaves as none)
  localparam logic [1:0] MEM_NONE  = 2'd0;
  localparam logic [1:0] MEM_LOAD  = 2'd1;
  localparam logic [1:0] MEM_STORE = 2'd2;

  // funct3 access size / sign
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_WB   = 2'd3
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } acc_size_e;

  // Unrecognised funct3 values fall back to a full word
  function automatic acc_size_e size_of(input logic [2:0] funct3);
    case (funct3)
      F3_B, F3_BU: size_of = SZ_B;
      F3_H, F3_HU: size_of = SZ_H;
      default:     size_of = SZ_W;
    endcase
  endfunction

  function automatic logic [3:0] store_be(input logic [2:0] funct3, input logic [1:0] addr_lo);
    case (size_of(funct3))
      SZ_B:    store_be = 4'(4'b0001 << addr_lo);
      SZ_H:    store_be = addr_lo[1] ? 4'b1100 : 4'b0011;
      default: store_be = 4'b1111;
    endcase
  endfunction

  // Replicate the stored byte/halfword across every lane it could land in
  function automatic logic [XLEN-1:0] store_lanes(input logic [2:0] funct3, input logic [XLEN-1:0] data);
    case (size_of(funct3))
      SZ_B:    store_lanes = {4{data[7:0]}};
      SZ_H:    store_lanes = {2{data[15:0]}};
      default: store_lanes = data;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] wb_mux(input logic [1:0] sel, input logic [XLEN-1:0] alu,
                                             input logic [XLEN-1:0] ld, input logic [XLEN-1:0] pc4);
    case (sel)
      WB_MEM:  wb_mux = ld;
      WB_PC4:  wb_mux = pc4;
      default: wb_mux = alu;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Load data aligner: picks the byte/halfword lane addressed by addr_lo out of
// the returned memory word and sign- or zero-extends it per funct3.
// Ports: rdata (memory word), addr_lo (byte offset), funct3, load_data_c (result).
module load_align
  import riscv_pkg::*;
(
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      addr_lo,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] load_data_c
);

  logic [7:0]  byte_c;
  logic [15:0] half_c;
  logic        unsigned_c;

  always_comb begin
    byte_c      = rdata[7:0];
    half_c      = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    unsigned_c  = funct3[2];
    load_data_c = rdata;
    case (addr_lo)
      2'd1:    byte_c = rdata[15:8];
      2'd2:    byte_c = rdata[23:16];
      2'd3:    byte_c = rdata[31:24];
      default: byte_c = rdata[7:0];
    endcase
    case (size_of(funct3))
      SZ_B:    load_data_c = unsigned_c ? {24'h0, byte_c} : {{24{byte_c[7]}}, byte_c};
      SZ_H:    load_data_c = unsigned_c ? {16'h0, half_c} : {{16{half_c[15]}}, half_c};
      default: load_data_c = rdata;
    endcase
  end

endmodule

// File: rtl/lsu_wb_stage.sv
// Load/store + write-back stage. Accepts one executed instruction, performs the
// data-memory access over req/gnt/rvalid, and drives the register-file write port.
// Ports: clk/rst (async active-high); ex_* handshake and instruction fields;
// mem_* request/response channel; w_en/rd_add/w_data register-file write;
// misalign_err pulse. Optional build macro LSU_MISALIGN_TRAP_EN traps misaligned
// H/W accesses instead of issuing them to memory.
module lsu_wb_stage
  import riscv_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [XLEN-1:0]   ex_alu_result,
  input  logic [XLEN-1:0]   ex_store_data,
  input  logic [XLEN-1:0]   ex_pc4,
  input  logic [4:0]        ex_rd_add,
  input  logic              ex_reg_write,
  input  logic [1:0]        ex_wb_sel,
  input  logic [1:0]        ex_mem_op,
  input  logic [2:0]        ex_funct3,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              w_en,
  output logic [4:0]        rd_add,
  output logic [XLEN-1:0]   w_data,
  output logic              misalign_err
);

  lsu_state_e        state_q, state_d;
  logic              ex_ready_q, ex_ready_d;
  logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
  logic              w_en_q, w_en_d, misalign_q, misalign_d;
  logic [4:0]        rd_add_q, rd_add_d;
  logic [XLEN-1:0]   w_data_q, w_data_d;

  // Instruction fields held across the memory access
  logic [XLEN-1:0]   alu_q, alu_d, pc4_q, pc4_d;
  logic [4:0]        rd_q, rd_d;
  logic              reg_write_q, reg_write_d;
  logic [1:0]        wb_sel_q, wb_sel_d;
  logic [2:0]        funct3_q, funct3_d;

  logic              is_mem_c, misaligned_c;
  logic [XLEN-1:0]   load_data_c;

  load_align u_load_align (
    .rdata       (mem_rdata),
    .addr_lo     (alu_q[1:0]),
    .funct3      (funct3_q),
    .load_data_c (load_data_c)
  );

  // Misalignment of the incoming access
  always_comb begin
    misaligned_c = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    case (size_of(ex_funct3))
      SZ_H:    misaligned_c = ex_alu_result[0];
      SZ_W:    misaligned_c = |ex_alu_result[1:0];
      default: misaligned_c = 1'b0;
    endcase
`endif
  end

  assign is_mem_c = (ex_mem_op == MEM_LOAD) || (ex_mem_op == MEM_STORE);

  // Next state and next registered outputs
  always_comb begin
    state_d     = state_q;
    mem_req_d   = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    w_en_d      = 1'b0;
    misalign_d  = 1'b0;
    rd_add_d    = rd_add_q;
    w_data_d    = w_data_q;
    alu_d       = alu_q;
    pc4_d       = pc4_q;
    rd_d        = rd_q;
    reg_write_d = reg_write_q;
    wb_sel_d    = wb_sel_q;
    funct3_d    = funct3_q;

    case (state_q)
      ST_IDLE, ST_WB: begin
        if (ex_valid && ex_ready_q) begin
          alu_d       = ex_alu_result;
          pc4_d       = ex_pc4;
          rd_d        = ex_rd_add;
          reg_write_d = ex_reg_write;
          wb_sel_d    = ex_wb_sel;
          funct3_d    = ex_funct3;
          if (is_mem_c && !misaligned_c) begin
            state_d     = ST_REQ;
            mem_req_d   = 1'b1;
            mem_we_d    = (ex_mem_op == MEM_STORE);
            mem_addr_d  = ADDR_W'({ex_alu_result[XLEN-1:2], 2'b00});
            mem_be_d    = store_be(ex_funct3, ex_alu_result[1:0]);
            mem_wdata_d = store_lanes(ex_funct3, ex_store_data);
          end else begin
            // Non-memory op, or a trapped misaligned access with its write squashed
            state_d    = ST_WB;
            w_en_d     = ex_reg_write && (ex_rd_add != 5'd0) && !misaligned_c;
            misalign_d = misaligned_c;
            rd_add_d   = ex_rd_add;
            w_data_d   = wb_mux(ex_wb_sel, ex_alu_result, XLEN'(0), ex_pc4);
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (mem_gnt) begin
          state_d = ST_RESP;
        end else begin
          mem_req_d = 1'b1;
          mem_we_d  = mem_we_q;
        end
      end
      ST_RESP: begin
        if (mem_rvalid) begin
          state_d  = ST_WB;
          w_en_d   = reg_write_q && (rd_q != 5'd0);
          rd_add_d = rd_q;
          w_data_d = wb_mux(wb_sel_q, alu_q, load_data_c, pc4_q);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    ex_ready_d = (state_d == ST_IDLE) || (state_d == ST_WB);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ex_ready_q  <= 1'b1;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= 4'h0;
      mem_wdata_q <= '0;
      w_en_q      <= 1'b0;
      misalign_q  <= 1'b0;
      rd_add_q    <= 5'd0;
      w_data_q    <= '0;
      alu_q       <= '0;
      pc4_q       <= '0;
      rd_q        <= 5'd0;
      reg_write_q <= 1'b0;
      wb_sel_q    <= WB_ALU;
      funct3_q    <= F3_W;
    end else begin
      state_q     <= state_d;
      ex_ready_q  <= ex_ready_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      w_en_q      <= w_en_d;
      misalign_q  <= misalign_d;
      rd_add_q    <= rd_add_d;
      w_data_q    <= w_data_d;
      alu_q       <= alu_d;
      pc4_q       <= pc4_d;
      rd_q        <= rd_d;
      reg_write_q <= reg_write_d;
      wb_sel_q    <= wb_sel_d;
      funct3_q    <= funct3_d;
    end
  end

  assign ex_ready     = ex_ready_q;
  assign mem_req      = mem_req_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_be       = mem_be_q;
  assign mem_wdata    = mem_wdata_q;
  assign w_en         = w_en_q;
  assign rd_add       = rd_add_q;
  assign w_data       = w_data_q;
  assign misalign_err = misalign_q;

endmodule

// File: tb/tb_lsu_wb_stage.sv
// Self-checking bench for lsu_wb_stage: expected write-backs are queued when an
// instruction is driven and popped when the register-file write appears.
module tb_lsu_wb_stage;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_ready;
  logic [31:0] ex_alu_result, ex_store_data, ex_pc4;
  logic [4:0]  ex_rd_add;
  logic        ex_reg_write;
  logic [1:0]  ex_wb_sel, ex_mem_op;
  logic [2:0]  ex_funct3;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        w_en, misalign_err;
  logic [4:0]  rd_add;
  logic [31:0] w_data;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_t;
  wb_t exp_q[$];

  int checks = 0;
  int failures = 0;
  int wen_count = 0;

  lsu_wb_stage #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data), .ex_pc4(ex_pc4),
    .ex_rd_add(ex_rd_add), .ex_reg_write(ex_reg_write), .ex_wb_sel(ex_wb_sel),
    .ex_mem_op(ex_mem_op), .ex_funct3(ex_funct3),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .w_en(w_en), .rd_add(rd_add), .w_data(w_data), .misalign_err(misalign_err)
  );

  initial forever #5 clk = ~clk;

  always @(negedge clk) if (w_en === 1'b1) wen_count++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic drive(input logic [31:0] alu, input logic [31:0] sd, input logic [31:0] pc4,
                       input logic [4:0] rd, input logic rw, input logic [1:0] sel,
                       input logic [1:0] op, input logic [2:0] f3);
    ex_alu_result = alu; ex_store_data = sd; ex_pc4 = pc4; ex_rd_add = rd;
    ex_reg_write = rw; ex_wb_sel = sel; ex_mem_op = op; ex_funct3 = f3; ex_valid = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; ex_valid = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    drive(0, 0, 0, 0, 0, WB_ALU, MEM_NONE, F3_W); ex_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({mem_req, mem_we, w_en, misalign_err, mem_be, mem_addr, mem_wdata, rd_add, w_data} !== 110'h0) begin
      failures++;
      $display("FAIL reset_outputs: got req=%b we=%b wen=%b mis=%b be=%h addr=%h wd=%h rd=%0d wdata=%h, want all 0",
               mem_req, mem_we, w_en, misalign_err, mem_be, mem_addr, mem_wdata, rd_add, w_data);
    end
    checks++;
    if (ex_ready !== 1'b1) begin failures++; $display("FAIL reset_ex_ready: got %b want 1", ex_ready); end
    rst = 1'b0;
  endtask

  task automatic test_alu();
    wb_t e;
    @(negedge clk);
    drive(32'h1234, 0, 32'h44, 5'd5, 1'b1, WB_ALU, MEM_NONE, F3_W);
    exp_q.push_back('{5'd5, 32'h0000_1234});
    @(posedge clk); #1 ex_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (w_en !== 1'b1) begin failures++; $display("FAIL alu_wen: got %b want 1", w_en); end
    checks++;
    if (exp_q.size() == 0) begin failures++; $display("FAIL alu_sb: scoreboard empty"); end
    else begin
      e = exp_q.pop_front();
      if ({rd_add, w_data} !== {e.rd, e.data}) begin
        failures++; $display("FAIL alu_wb: got rd=%0d data=%h want rd=%0d data=%h", rd_add, w_data, e.rd, e.data);
      end
    end
    @(negedge clk);
    checks++;
    if (w_en !== 1'b0) begin failures++; $display("FAIL alu_wen_drop: got %b want 0", w_en); end
  endtask

  task automatic test_x0();
    int snap;
    @(negedge clk);
    snap = wen_count;
    drive(32'hFFFF_0000, 0, 0, 5'd0, 1'b1, WB_ALU, MEM_NONE, F3_W);
    @(posedge clk); #1 ex_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (w_en !== 1'b0) begin failures++; $display("FAIL x0_wen: got %b want 0", w_en); end
    @(negedge clk);
    checks++;
    if (wen_count != snap) begin failures++; $display("FAIL x0_count: got %0d writes want %0d", wen_count, snap); end
  endtask

  task automatic test_back_to_back();
    logic [1:0]  sels[4] = '{WB_ALU, WB_PC4, 2'd3, WB_ALU};
    logic [31:0] alus[4] = '{32'h11, 32'h22, 32'h33, 32'h44};
    logic [31:0] pcs[4]  = '{32'h104, 32'h208, 32'h30C, 32'h410};
    wb_t e;
    @(negedge clk);
    drive(alus[0], 0, pcs[0], 5'd1, 1'b1, sels[0], MEM_NONE, F3_W);
    exp_q.push_back('{5'd1, alus[0]});
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (i < 3) begin
        drive(alus[i+1], 0, pcs[i+1], 5'(i + 2), 1'b1, sels[i+1], MEM_NONE, F3_W);
        exp_q.push_back('{5'(i + 2), (sels[i+1] == WB_PC4) ? pcs[i+1] : alus[i+1]});
      end else ex_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (w_en !== 1'b1 || exp_q.size() == 0) begin
        failures++; $display("FAIL b2b_wen[%0d]: got wen=%b want 1", i, w_en);
      end else begin
        e = exp_q.pop_front();
        if ({rd_add, w_data} !== {e.rd, e.data}) begin
          failures++; $display("FAIL b2b_wb[%0d]: got rd=%0d data=%h want rd=%0d data=%h", i, rd_add, w_data, e.rd, e.data);
        end
      end
    end
  endtask

  task automatic test_load();
    logic [31:0] addrs[5] = '{32'h103, 32'h103, 32'h102, 32'h100, 32'h104};
    logic [2:0]  f3s[5]   = '{F3_B, F3_BU, F3_H, F3_HU, F3_W};
    logic [31:0] rds[5]   = '{32'h80FF_0000, 32'h80FF_0000, 32'h8001_1234, 32'h8001_F00D, 32'hDEAD_BEEF};
    logic [31:0] exps[5]  = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001, 32'h0000_F00D, 32'hDEAD_BEEF};
    wb_t e;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive(addrs[i], 0, 0, 5'd10, 1'b1, WB_MEM, MEM_LOAD, f3s[i]);
      mem_gnt = 1'b1;
      exp_q.push_back('{5'd10, exps[i]});
      @(posedge clk); #1 ex_valid = 1'b0;
      @(negedge clk);
      checks++;
      if ({mem_req, mem_we, mem_addr, ex_ready} !== {1'b1, 1'b0, addrs[i] & 32'hFFFF_FFFC, 1'b0}) begin
        failures++; $display("FAIL load_req[%0d]: got req=%b we=%b addr=%h rdy=%b want req=1 we=0 addr=%h rdy=0",
                             i, mem_req, mem_we, mem_addr, ex_ready, addrs[i] & 32'hFFFF_FFFC);
      end
      @(posedge clk); #1 mem_rvalid = 1'b1; mem_rdata = rds[i];
      @(negedge clk);
      checks++;
      if ({mem_req, ex_ready, w_en} !== 3'b000) begin
        failures++; $display("FAIL load_resp[%0d]: got req=%b rdy=%b wen=%b want 000", i, mem_req, ex_ready, w_en);
      end
      @(posedge clk); #1 mem_rvalid = 1'b0; mem_gnt = 1'b0;
      @(negedge clk);
      checks++;
      if (w_en !== 1'b1 || exp_q.size() == 0) begin
        failures++; $display("FAIL load_wen[%0d]: got %b want 1", i, w_en);
      end else begin
        e = exp_q.pop_front();
        if ({rd_add, w_data} !== {e.rd, e.data}) begin
          failures++; $display("FAIL load_data[%0d]: got rd=%0d data=%h want rd=%0d data=%h", i, rd_add, w_data, e.rd, e.data);
        end
      end
    end
  endtask

  task automatic test_store_stall();
    int snap;
    @(negedge clk);
    snap = wen_count;
    mem_gnt = 1'b0;
    drive(32'h202, 32'h5555_ABCD, 0, 5'd0, 1'b0, WB_ALU, MEM_STORE, F3_H);
    @(posedge clk); #1 ex_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({mem_req, mem_we, mem_addr, mem_be, mem_wdata, ex_ready} !==
          {1'b1, 1'b1, 32'h200, 4'b1100, 32'hABCD_ABCD, 1'b0}) begin
        failures++; $display("FAIL sh_hold[%0d]: got req=%b we=%b addr=%h be=%b wd=%h rdy=%b want 1 1 00000200 1100 abcdabcd 0",
                             i, mem_req, mem_we, mem_addr, mem_be, mem_wdata, ex_ready);
      end
    end
    mem_gnt = 1'b1;
    @(posedge clk); #1 mem_gnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({mem_req, ex_ready} !== 2'b00) begin
        failures++; $display("FAIL sh_wait[%0d]: got req=%b rdy=%b want 00", i, mem_req, ex_ready);
      end
    end
    mem_rvalid = 1'b1;
    @(posedge clk); #1 mem_rvalid = 1'b0;
    @(negedge clk);
    checks++;
    if ({ex_ready, w_en} !== 2'b10) begin
      failures++; $display("FAIL sh_done: got rdy=%b wen=%b want rdy=1 wen=0", ex_ready, w_en);
    end
    // SB with the grant tied high
    @(negedge clk);
    drive(32'h101, 32'h1234_56EF, 0, 5'd0, 1'b0, WB_ALU, MEM_STORE, F3_B);
    mem_gnt = 1'b1;
    @(posedge clk); #1 ex_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({mem_req, mem_we, mem_addr, mem_be, mem_wdata} !== {1'b1, 1'b1, 32'h100, 4'b0010, 32'hEFEF_EFEF}) begin
      failures++; $display("FAIL sb_req: got req=%b we=%b addr=%h be=%b wd=%h want 1 1 00000100 0010 efefefef",
                           mem_req, mem_we, mem_addr, mem_be, mem_wdata);
    end
    @(posedge clk); #1 mem_gnt = 1'b0; mem_rvalid = 1'b1;
    @(posedge clk); #1 mem_rvalid = 1'b0;
    @(negedge clk);
    checks++;
    if (wen_count != snap) begin failures++; $display("FAIL store_no_write: got %0d writes want %0d", wen_count, snap); end
  endtask

  task automatic test_misalign();
    wb_t e;
    int snap;
    @(negedge clk);
    snap = wen_count;
`ifdef LSU_MISALIGN_TRAP_EN
    drive(32'h101, 0, 0, 5'd7, 1'b1, WB_MEM, MEM_LOAD, F3_W);
    @(posedge clk); #1 ex_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({mem_req, misalign_err, w_en} !== 3'b010) begin
      failures++; $display("FAIL mis_trap: got req=%b err=%b wen=%b want 0 1 0", mem_req, misalign_err, w_en);
    end
    @(negedge clk);
    checks++;
    if ({mem_req, misalign_err, w_en} !== 3'b000 || wen_count != snap) begin
      failures++; $display("FAIL mis_after: got req=%b err=%b wen=%b writes=%0d want 0 0 0 writes=%0d",
                           mem_req, misalign_err, w_en, wen_count, snap);
    end
`else
    drive(32'h101, 0, 0, 5'd7, 1'b1, WB_MEM, MEM_LOAD, F3_W);
    mem_gnt = 1'b1;
    exp_q.push_back('{5'd7, 32'hCAFE_F00D});
    @(posedge clk); #1 ex_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({mem_req, mem_addr, mem_be, misalign_err} !== {1'b1, 32'h100, 4'b1111, 1'b0}) begin
      failures++; $display("FAIL lw_unaligned_req: got req=%b addr=%h be=%b err=%b want 1 00000100 1111 0",
                           mem_req, mem_addr, mem_be, misalign_err);
    end
    @(posedge clk); #1 mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
    @(posedge clk); #1 mem_rvalid = 1'b0; mem_gnt = 1'b0;
    @(negedge clk);
    checks++;
    if (w_en !== 1'b1 || misalign_err !== 1'b0 || exp_q.size() == 0) begin
      failures++; $display("FAIL lw_unaligned_wen: got wen=%b err=%b want 1 0", w_en, misalign_err);
    end else begin
      e = exp_q.pop_front();
      if ({rd_add, w_data} !== {e.rd, e.data}) begin
        failures++; $display("FAIL lw_unaligned_data: got rd=%0d data=%h want rd=%0d data=%h", rd_add, w_data, e.rd, e.data);
      end
    end
`endif
  endtask

  task automatic test_reset_mid();
    int snap;
    @(negedge clk);
    drive(32'h300, 0, 0, 5'd9, 1'b1, WB_MEM, MEM_LOAD, F3_W);
    mem_gnt = 1'b1;
    @(posedge clk); #1 ex_valid = 1'b0;
    @(posedge clk); #1 mem_gnt = 1'b0;
    @(negedge clk);
    checks++;
    if ({mem_req, ex_ready} !== 2'b00) begin
      failures++; $display("FAIL rstmid_resp: got req=%b rdy=%b want 00", mem_req, ex_ready);
    end
    snap = wen_count;
    rst = 1'b1;
    #1;
    checks++;
    if ({mem_req, mem_we, w_en, misalign_err, mem_be, mem_addr, mem_wdata, rd_add, w_data} !== 110'h0) begin
      failures++; $display("FAIL rstmid_outputs: got req=%b we=%b wen=%b mis=%b be=%h addr=%h wd=%h rd=%0d wdata=%h, want all 0",
                           mem_req, mem_we, w_en, misalign_err, mem_be, mem_addr, mem_wdata, rd_add, w_data);
    end
    @(negedge clk); rst = 1'b0;
    @(negedge clk); mem_rvalid = 1'b1; mem_rdata = 32'h7777_7777;
    @(negedge clk); mem_rvalid = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (wen_count != snap || ex_ready !== 1'b1) begin
      failures++; $display("FAIL rstmid_late_resp: got writes=%0d rdy=%b want writes=%0d rdy=1", wen_count, ex_ready, snap);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_x0();
    test_back_to_back();
    test_load();
    test_store_stall();
    test_misalign();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL sb_drain: %0d expected writes never seen", exp_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
